// File: rtl/mul_share_pkg.sv
// Shared types for the multiplier-sharing arbiter.
// Id fields are sized for the largest requester count (8).
package mul_share_pkg;
    localparam int OPW = 4;
    localparam int PW = 8;
    localparam int IDW_MAX = 3;

    typedef logic [IDW_MAX-1:0] id_t;

    typedef struct packed {
        id_t            id;
        logic [PW-1:0]  product;
    } rsp_entry_t;

    typedef struct packed {
        logic valid;
        id_t  id;
    } tag_t;
endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request, multiplier and response signals of the shared multiplier.
// master = clients plus multiplier, slave = arbiter.
interface mul_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                      req_valid;
    logic [NUM_REQ-1:0]                      req_ready;
    logic [NUM_REQ*mul_share_pkg::OPW-1:0]   req_a;
    logic [NUM_REQ*mul_share_pkg::OPW-1:0]   req_b;
    logic [mul_share_pkg::OPW-1:0]           mul_a;
    logic [mul_share_pkg::OPW-1:0]           mul_b;
    logic [mul_share_pkg::PW-1:0]            mul_p;
    logic                                    rsp_valid;
    logic                                    rsp_ready;
    logic [ID_W-1:0]                         rsp_id;
    logic [mul_share_pkg::PW-1:0]            rsp_p;
    logic                                    busy;

    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, busy
    );
endinterface

// File: rtl/mul_share_rsp_fifo.sv
// Synchronous result FIFO with binary pointers and occupancy count.
// Reads as zero when empty.
module mul_share_rsp_fifo
    import mul_share_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  rsp_entry_t    wdata,
    input  logic          pop,
    output rsp_entry_t    rdata,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_pop;

    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = (count != '0) ? mem[rd_ptr] : '0;

    // Credits upstream make a push into a full FIFO impossible.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset)
        !(push && count == CW'(DEPTH))
    );
endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one registered 4x4 multiplier among NUM_REQ
// clients, with a tag pipe tracking in-flight ops and a result FIFO.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input logic                clk,
    input logic                reset,
    mul_share_arbiter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    logic            can_issue;
    logic [CW-1:0]   fifo_count;
    tag_t            tag_q [MUL_LAT];
    rsp_entry_t      fifo_wdata;
    rsp_entry_t      fifo_rdata;
    logic            tags_busy;
    int              inflight;
    int              idx;
    logic            unused_id_bits;

    // Pops do not return credit in the same cycle, so req_ready
    // never depends on rsp_ready.
    always_comb begin
        inflight = 0;
        tags_busy = 1'b0;
        for (int s = 0; s < MUL_LAT; s++) begin
            inflight += int'(tag_q[s].valid);
            tags_busy |= tag_q[s].valid;
        end
        can_issue = (int'(fifo_count) + inflight) < FIFO_DEPTH;
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_id = '0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_any && bus.req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
        if (reset || !can_issue) begin
            gnt_any = 1'b0;
            gnt_id = '0;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.mul_a = '0;
        bus.mul_b = '0;
        if (gnt_any) begin
            bus.req_ready[gnt_id] = 1'b1;
            bus.mul_a = bus.req_a[gnt_id*OPW +: OPW];
            bus.mul_b = bus.req_b[gnt_id*OPW +: OPW];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (gnt_any)
            rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0
                                                     : gnt_id + ID_W'(1);
    end

    // Tag stage MUL_LAT-1 lines up with the product on mul_p.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < MUL_LAT; s++)
                tag_q[s] <= '0;
        end else begin
            tag_q[0].valid <= gnt_any;
            tag_q[0].id <= IDW_MAX'(gnt_id);
            for (int s = 1; s < MUL_LAT; s++)
                tag_q[s] <= tag_q[s-1];
        end
    end

    always_comb begin
        fifo_wdata.id = tag_q[MUL_LAT-1].id;
        fifo_wdata.product = bus.mul_p;
    end

    mul_share_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tag_q[MUL_LAT-1].valid),
        .wdata (fifo_wdata),
        .pop   (bus.rsp_valid && bus.rsp_ready),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign bus.rsp_valid = (fifo_count != '0);
    assign bus.rsp_id = fifo_rdata.id[ID_W-1:0];
    assign bus.rsp_p = fifo_rdata.product;
    assign bus.busy = tags_busy || (fifo_count != '0);
    assign unused_id_bits = ^fifo_rdata.id;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter with a queue-based model
// and a behavioural two-stage registered multiplier.
module tb_mul_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 2;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_share_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    mul_share_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Multiplier with input and output registers: 2-cycle latency.
    logic [3:0] ma_q, mb_q;
    logic [7:0] mp_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ma_q <= '0;
            mb_q <= '0;
            mp_q <= '0;
        end else begin
            ma_q <= bus.mul_a;
            mb_q <= bus.mul_b;
            mp_q <= 8'(ma_q) * 8'(mb_q);
        end
    end
    assign bus.mul_p = mp_q;

    typedef struct { int id; int p; } ent_t;
    typedef struct { int id; int p; int cnt; } fly_t;
    typedef struct { int id; int a; int b; int p; } vec_t;

    ent_t m_fifo[$];
    fly_t m_fly[$];
    int   m_ptr;

    int n_checks = 0;
    int n_fail = 0;
    int last_g, acc_cnt, pop_cnt;
    int s_ready, s_rsp_valid, s_rsp_id, s_rsp_p, s_busy;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_fifo.delete();
        m_fly.delete();
        m_ptr = 0;
    endtask

    // One clock: compare all outputs with the model, then advance it.
    task automatic step();
        int g, ea, eb, occ;
        bit pop;
        ent_t head;
        fly_t keep[$];
        @(negedge clk);
        g = -1;
        ea = 0;
        eb = 0;
        occ = m_fifo.size() + m_fly.size();
        if (!reset && occ < FIFO_DEPTH)
            for (int k = 0; k < NUM_REQ; k++)
                if (g < 0 && bus.req_valid[(m_ptr + k) % NUM_REQ])
                    g = (m_ptr + k) % NUM_REQ;
        if (g >= 0) begin
            ea = int'(bus.req_a[g*4 +: 4]);
            eb = int'(bus.req_b[g*4 +: 4]);
        end
        head.id = 0;
        head.p = 0;
        if (m_fifo.size() > 0)
            head = m_fifo[0];
        check("req_ready", int'(bus.req_ready), (g >= 0) ? (1 << g) : 0);
        check("mul_a", int'(bus.mul_a), ea);
        check("mul_b", int'(bus.mul_b), eb);
        check("rsp_valid", int'(bus.rsp_valid), int'(m_fifo.size() > 0));
        check("rsp_id", int'(bus.rsp_id), head.id);
        check("rsp_p", int'(bus.rsp_p), head.p);
        check("busy", int'(bus.busy), int'(occ > 0));
        s_ready = int'(bus.req_ready);
        s_rsp_valid = int'(bus.rsp_valid);
        s_rsp_id = int'(bus.rsp_id);
        s_rsp_p = int'(bus.rsp_p);
        s_busy = int'(bus.busy);
        pop = (m_fifo.size() > 0) && bus.rsp_ready;
        last_g = g;
        @(posedge clk);
        if (!reset) begin
            if (pop) begin
                void'(m_fifo.pop_front());
                pop_cnt++;
            end
            foreach (m_fly[j]) begin
                if (m_fly[j].cnt == 1)
                    m_fifo.push_back('{m_fly[j].id, m_fly[j].p});
                else
                    keep.push_back('{m_fly[j].id, m_fly[j].p, m_fly[j].cnt - 1});
            end
            m_fly = keep;
            if (g >= 0) begin
                m_fly.push_back('{g, ea * eb, MUL_LAT});
                m_ptr = (g + 1) % NUM_REQ;
                acc_cnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        int order[4];
        int lat, n, a0, p0, seen;
        vecs[0] = '{0, 3, 5, 15};
        vecs[1] = '{1, 15, 15, 225};
        vecs[2] = '{2, 0, 9, 0};
        vecs[3] = '{3, 7, 8, 56};
        vecs[4] = '{0, 15, 1, 15};
        vecs[5] = '{1, 12, 12, 144};

        acc_cnt = 0;
        pop_cnt = 0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        model_clear();

        // Requests during reset must never be granted.
        bus.req_valid = '1;
        step();
        step();
        check("reset_req_ready", s_ready, 0);
        check("reset_rsp_valid", s_rsp_valid, 0);
        check("reset_busy", s_busy, 0);
        check("reset_rsp_p", s_rsp_p, 0);
        bus.req_valid = '0;
        reset = 1'b0;

        // Single requests: fixed latency and product values.
        foreach (vecs[v]) begin
            bus.req_a[vecs[v].id*4 +: 4] = 4'(vecs[v].a);
            bus.req_b[vecs[v].id*4 +: 4] = 4'(vecs[v].b);
            bus.req_valid = '0;
            bus.req_valid[vecs[v].id] = 1'b1;
            bus.rsp_ready = 1'b1;
            for (int c = 0; c < 10; c++) begin
                step();
                if (last_g == vecs[v].id)
                    break;
            end
            check("vec_accept", last_g, vecs[v].id);
            bus.req_valid = '0;
            lat = 0;
            while (lat < 8) begin
                step();
                lat++;
                if (s_rsp_valid != 0)
                    break;
            end
            check("vec_latency", lat, 3);
            check("vec_id", s_rsp_id, vecs[v].id);
            check("vec_p", s_rsp_p, vecs[v].p);
            step();
            check("vec_busy_after_pop", s_busy, 0);
        end

        // Round-robin under backpressure: exactly FIFO_DEPTH accepts.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*4 +: 4] = 4'(i + 1);
            bus.req_b[i*4 +: 4] = 4'd2;
            order[i] = -1;
        end
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        a0 = acc_cnt;
        n = 0;
        repeat (8) begin
            step();
            if (last_g >= 0 && n < 4) begin
                order[n] = last_g;
                n++;
            end
        end
        check("bp_accepts", acc_cnt - a0, 4);
        for (int i = 0; i < 4; i++)
            check("rr_order", order[i], i);
        check("bp_ready_stalled", s_ready, 0);
        bus.rsp_ready = 1'b1;
        n = 0;
        repeat (8) begin
            step();
            if (s_rsp_valid != 0 && n < 4) begin
                check("rr_rsp_id", s_rsp_id, n);
                check("rr_rsp_p", s_rsp_p, 2 * (n + 1));
                n++;
            end
        end
        check("rr_rsp_count", n, 4);

        // Sustained throughput: one accept and one pop every cycle.
        repeat (6) step();
        a0 = acc_cnt;
        p0 = pop_cnt;
        repeat (20) step();
        check("tput_accepts", acc_cnt - a0, 20);
        check("tput_pops", pop_cnt - p0, 20);

        // Reset one cycle after two ops are issued.
        bus.req_valid = '0;
        repeat (8) step();
        do_reset();
        bus.req_valid = 4'b0110;
        step();
        step();
        check("mf_second_grant", last_g, 2);
        bus.req_valid = '1;
        reset = 1'b1;
        model_clear();
        step();
        check("mf_reset_ready", s_ready, 0);
        check("mf_reset_rsp_valid", s_rsp_valid, 0);
        check("mf_reset_busy", s_busy, 0);
        reset = 1'b0;
        step();
        check("mf_first_grant", last_g, 0);
        bus.req_valid = '0;
        seen = 0;
        repeat (6) begin
            step();
            if (s_rsp_valid != 0)
                seen++;
        end
        check("mf_no_stale", seen, 1);

        // Random traffic against the model; clients hold until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_a[i*4 +: 4] = 4'($urandom);
                    bus.req_b[i*4 +: 4] = 4'($urandom);
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            if (last_g >= 0)
                bus.req_valid[last_g] = 1'b0;
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (10) step();
        check("drain_busy", s_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one registered 4x4 Dadda multiplier instance among NUM_REQ requesters. The multiplier instance has input and output flip-flops, giving 2-cycle latency.
- Arbitrates request channels round-robin and drives operands to the multiplier.
- Tracks in-flight operations with a tag pipeline.
- Collects products into a result FIFO and returns them on one shared response channel with valid/ready backpressure.
- Sits between client blocks and dadda_multiplier_with_io_ff; both use the same clk/reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LAT, 2, cycles from operand issue to product on mul_p; must match the multiplier instance.
- FIFO_DEPTH, 4, result FIFO entries (power of 2, >= MUL_LAT).
- ID_W, $clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  NUM_REQ*4  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*4  operand B; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted when valid&ready.
- mul_a  out  4  operand A to the multiplier's A_in.
- mul_b  out  4  operand B to the multiplier's B_in.
- mul_p  in  8  registered product from the multiplier's P_reg_out.
- rsp_valid  out  1  result FIFO non-empty.
- rsp_ready  in  1  consumer accepts the head entry.
- rsp_id  out  ID_W  requester index of the head entry.
- rsp_p  out  8  product of the head entry.
- busy  out  1  any operation in flight or FIFO non-empty.

Behaviour:
Reset state:
- Round-robin pointer = 0; tag pipeline valid bits = 0; FIFO empty.
- req_ready = 0, rsp_valid = 0, busy = 0; rsp_id/rsp_p = 0 when empty.

Credit check (combinational):
- can_issue = (fifo_count + inflight_count) < FIFO_DEPTH, where inflight_count = number of set tag-pipe valid bits.
- A pop in the same cycle does not add credit in that cycle. This keeps the logic conservative and free of combinational paths from rsp_ready to req_ready.

Arbitration:
- Combinational; at most one req_ready bit set, only when can_issue.
- Search starts at the pointer and proceeds upward with wrap; the first i with req_valid[i] is granted.
- On grant, pointer <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
- req_ready must not depend on req_a/req_b.
- Requesters hold valid and operands stable until accepted. The arbiter does not require this for correctness because operands are sampled only in the accept cycle.

Issue:
- mul_a/mul_b = granted requester's operands in the accept cycle; 4'h0 otherwise.
- Tag pipeline stage 0 captures {1, i} at the edge; the stage shifts every cycle, MUL_LAT stages deep.
- Accept in cycle t means mul_p holds A*B during cycle t+MUL_LAT. When the last tag stage is valid, {id, mul_p} is written to the FIFO at the end of that cycle. The response is visible from cycle t+MUL_LAT+1.
- Back-to-back issue is allowed every cycle, giving 1 result/cycle throughput while credits last.

Result FIFO:
- Depth FIFO_DEPTH; binary read/write pointers with a wrapping count.
- Pop on rsp_valid & rsp_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Overflow is impossible by construction; an SVA asserts that no push ever occurs when full.

Other rules:
- busy = |tag_valid | (fifo_count != 0).
- Reset mid-operation clears tags, FIFO and pointer at once. In-flight results are discarded. The multiplier's own registers clear on the same reset, so the next mul_p is 0.
- Products are unsigned 8-bit; no truncation (15*15 = 225).

Decomposition:
- Shared package mul_share_pkg:
  - OPW = 4 and PW = 8.
  - Typedef rsp_entry_t {id, product} for the FIFO word.
  - Typedef tag_t {valid, id}.
- One sub-module: mul_share_rsp_fifo (parameterised synchronous FIFO of rsp_entry_t, count output). Arbiter, tag pipe and credit logic stay in the top.
- The multiplier is instantiated by the parent, not inside this block.

Test Plan:
- Single request: req0 A=3, B=5, rsp_ready=1, accept at cycle t. Expect rsp_valid at t+3 with id=0, p=15, busy falling after pop.
- Round-robin: req0..3 all valid continuously with A=i+1, B=2. Expect grants in order 0,1,2,3, then 0 again with credit stalls. Responses in order, p = 2,4,6,8.
- Backpressure: rsp_ready=0 with requesters saturated. Expect exactly 4 accepts, then req_ready=0. Set rsp_ready=1: one new accept per pop; no FIFO overflow (assertion).
- Simultaneous push/pop at FIFO full-1 with continuous traffic and rsp_ready=1. Expect sustained 1 result/cycle after a 3-cycle fill, and count stable.
- Boundary operands: A=15, B=15 gives p=225; A=0, B=9 gives p=0; pointer wrap from requester 3 to requester 0.
- Reset mid-flight: assert reset 1 cycle after issuing 2 ops. Expect rsp_valid=0, busy=0, req_ready=0 during reset. After release, the first grant goes to requester 0 and no stale responses appear.
